// File: rtl/falafel_op_scheduler.sv
// Operation scheduler for the falafel allocator core.
// Pops alloc/free operations from two first-word-fall-through FIFOs,
// issues one at a time to the core with a weighted alloc/free arbiter,
// and pushes the tagged core result into the response FIFO.
module falafel_op_scheduler #(
    parameter int                  DATA_W       = 64,
    parameter int                  MSG_ID_W     = 8,
    parameter int                  ALLOC_WEIGHT = 4,
    parameter logic [MSG_ID_W-1:0] FREE_TAG     = {MSG_ID_W{1'b1}}
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_empty_i,
    input  logic [DATA_W-1:0]          alloc_size_i,
    input  logic [MSG_ID_W-1:0]        alloc_id_i,
    output logic                       alloc_read_o,
    input  logic                       free_empty_i,
    input  logic [DATA_W-1:0]          free_addr_i,
    output logic                       free_read_o,
    output logic                       core_req_val_o,
    input  logic                       core_req_rdy_i,
    output logic                       core_is_alloc_o,
    output logic [DATA_W-1:0]          core_size_o,
    output logic [DATA_W-1:0]          core_addr_o,
    input  logic                       core_rsp_val_i,
    output logic                       core_rsp_rdy_o,
    input  logic [DATA_W-1:0]          core_rsp_data_i,
    input  logic                       resp_full_i,
    output logic                       resp_write_o,
    output logic [MSG_ID_W+DATA_W-1:0] resp_data_o,
    output logic                       busy_o
);

    localparam int STREAK_W = $clog2(ALLOC_WEIGHT + 1);
    localparam logic [STREAK_W-1:0] WEIGHT = STREAK_W'(ALLOC_WEIGHT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [STREAK_W-1:0]   streak_reg, streak_next;
    logic                  is_alloc_reg, is_alloc_next;
    logic [MSG_ID_W-1:0]   id_reg, id_next;
    logic [DATA_W-1:0]     size_reg, size_next;
    logic [DATA_W-1:0]     addr_reg, addr_next;
    // Low for the first cycle after reset release so no FIFO is popped then.
    logic                  started_reg;

    // Alloc wins unless a free is waiting and the alloc streak has hit its weight.
    logic pick_alloc;
    assign pick_alloc = !alloc_empty_i && (free_empty_i || (streak_reg < WEIGHT));

    // State, streak counter and latched operation registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            streak_reg   <= '0;
            is_alloc_reg <= 1'b0;
            id_reg       <= '0;
            size_reg     <= '0;
            addr_reg     <= '0;
            started_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            streak_reg   <= streak_next;
            is_alloc_reg <= is_alloc_next;
            id_reg       <= id_next;
            size_reg     <= size_next;
            addr_reg     <= addr_next;
            started_reg  <= 1'b1;
        end
    end

    // Next-state logic, grant/latch decisions and handshake outputs.
    always_comb begin
        state_next     = state_reg;
        streak_next    = streak_reg;
        is_alloc_next  = is_alloc_reg;
        id_next        = id_reg;
        size_next      = size_reg;
        addr_next      = addr_reg;
        alloc_read_o   = 1'b0;
        free_read_o    = 1'b0;
        core_req_val_o = 1'b0;
        core_rsp_rdy_o = 1'b0;
        resp_write_o   = 1'b0;
        resp_data_o    = '0;
        case (state_reg)
            IDLE: begin
                if (started_reg && (!alloc_empty_i || !free_empty_i)) begin
                    state_next = ISSUE;
                    if (pick_alloc) begin
                        alloc_read_o  = 1'b1;
                        is_alloc_next = 1'b1;
                        id_next       = alloc_id_i;
                        size_next     = alloc_size_i;
                        addr_next     = '0;
                        // Only count allocs that actually kept a free waiting.
                        if (free_empty_i) begin
                            streak_next = '0;
                        end else if (streak_reg != WEIGHT) begin
                            streak_next = streak_reg + 1'b1;
                        end
                    end else begin
                        free_read_o   = 1'b1;
                        is_alloc_next = 1'b0;
                        id_next       = '0;
                        size_next     = '0;
                        addr_next     = free_addr_i;
                        streak_next   = '0;
                    end
                end
            end
            ISSUE: begin
                core_req_val_o = 1'b1;
                if (core_req_rdy_i) begin
                    state_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                core_rsp_rdy_o = !resp_full_i;
                if (core_rsp_val_i && !resp_full_i) begin
                    resp_write_o = 1'b1;
                    resp_data_o  = {(is_alloc_reg ? id_reg : FREE_TAG), core_rsp_data_i};
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign core_is_alloc_o = is_alloc_reg;
    assign core_size_o     = size_reg;
    assign core_addr_o     = addr_reg;
    assign busy_o          = (state_reg != IDLE);

endmodule

// File: tb/tb_falafel_op_scheduler.sv
// Self-checking bench for falafel_op_scheduler: directed scenarios followed
// by randomized traffic, checked against an operation-level reference model.
module tb_falafel_op_scheduler;

    localparam int DW = 64;
    localparam int IW = 8;
    localparam int WEIGHT = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_empty, alloc_read, free_empty, free_read;
    logic [DW-1:0]  alloc_size, free_addr;
    logic [IW-1:0]  alloc_id;
    logic           core_req_val, core_req_rdy, core_is_alloc;
    logic [DW-1:0]  core_size, core_addr, core_rsp_data;
    logic           core_rsp_val, core_rsp_rdy, resp_full, resp_write, busy;
    logic [IW+DW-1:0] resp_data;

    falafel_op_scheduler dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_empty_i(alloc_empty), .alloc_size_i(alloc_size), .alloc_id_i(alloc_id),
        .alloc_read_o(alloc_read),
        .free_empty_i(free_empty), .free_addr_i(free_addr), .free_read_o(free_read),
        .core_req_val_o(core_req_val), .core_req_rdy_i(core_req_rdy),
        .core_is_alloc_o(core_is_alloc), .core_size_o(core_size), .core_addr_o(core_addr),
        .core_rsp_val_i(core_rsp_val), .core_rsp_rdy_o(core_rsp_rdy),
        .core_rsp_data_i(core_rsp_data),
        .resp_full_i(resp_full), .resp_write_o(resp_write), .resp_data_o(resp_data),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] size;
    } aop_t;

    aop_t          alloc_q[$];
    logic [DW-1:0] free_q[$];

    // Reference model: which operation is outstanding and where it is.
    int            m_mode;       // 0 none, 1 waiting for core accept, 2 waiting for result
    bit            m_alloc;
    logic [IW-1:0] m_id;
    logic [DW-1:0] m_size, m_addr;
    int            m_streak;     // allocs granted in a row while a free was waiting
    bit            m_fresh;      // first cycle after reset release
    bit            grants[$];    // 1 = alloc granted, 0 = free granted
    int            pushes;
    logic [IW+DW-1:0] last_resp;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_alloc_read"}, alloc_read, 0);
        chk({tag, "_free_read"}, free_read, 0);
        chk({tag, "_req_val"}, core_req_val, 0);
        chk({tag, "_is_alloc"}, core_is_alloc, 0);
        chk({tag, "_size"}, core_size, 0);
        chk({tag, "_addr"}, core_addr, 0);
        chk({tag, "_rsp_rdy"}, core_rsp_rdy, 0);
        chk({tag, "_resp_write"}, resp_write, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One clock cycle: present FIFO heads, check outputs mid-cycle against the
    // model, then apply pops after the edge.
    task automatic tick();
        bit want_a, want_f;
        alloc_empty = (alloc_q.size() == 0);
        alloc_id    = alloc_empty ? '0 : alloc_q[0].id;
        alloc_size  = alloc_empty ? '0 : alloc_q[0].size;
        free_empty  = (free_q.size() == 0);
        free_addr   = free_empty ? '0 : free_q[0];
        @(negedge clk);
        want_a = 0;
        want_f = 0;
        chk("busy", busy, m_mode != 0);
        case (m_mode)
            0: begin
                if (!m_fresh && (alloc_q.size() > 0 || free_q.size() > 0)) begin
                    if (alloc_q.size() > 0 && (free_q.size() == 0 || m_streak < WEIGHT)) want_a = 1;
                    else want_f = 1;
                end
                chk("alloc_read", alloc_read, want_a);
                chk("free_read", free_read, want_f);
                chk("idle_req_val", core_req_val, 0);
                chk("idle_rsp_rdy", core_rsp_rdy, 0);
                chk("idle_resp_write", resp_write, 0);
                if (want_a) begin
                    m_alloc = 1; m_id = alloc_q[0].id; m_size = alloc_q[0].size; m_addr = '0;
                    m_streak = (free_q.size() > 0) ? ((m_streak < WEIGHT) ? m_streak + 1 : WEIGHT) : 0;
                    grants.push_back(1'b1);
                    m_mode = 1;
                end else if (want_f) begin
                    m_alloc = 0; m_id = '1; m_size = '0; m_addr = free_q[0];
                    m_streak = 0;
                    grants.push_back(1'b0);
                    m_mode = 1;
                end
            end
            1: begin
                chk("req_val", core_req_val, 1);
                chk("is_alloc", core_is_alloc, m_alloc);
                chk("size", core_size, m_size);
                chk("addr", core_addr, m_addr);
                chk("issue_reads", {alloc_read, free_read}, 0);
                chk("issue_rsp_rdy", core_rsp_rdy, 0);
                chk("issue_resp_write", resp_write, 0);
                if (core_req_rdy) m_mode = 2;
            end
            default: begin
                chk("wait_req_val", core_req_val, 0);
                chk("wait_reads", {alloc_read, free_read}, 0);
                chk("rsp_rdy", core_rsp_rdy, !resp_full);
                chk("resp_write", resp_write, core_rsp_val && !resp_full);
                if (core_rsp_val && !resp_full) begin
                    chk("resp_data", resp_data, {(m_alloc ? m_id : 8'hFF), core_rsp_data});
                    last_resp = resp_data;
                    pushes++;
                    m_mode = 0;
                end
            end
        endcase
        m_fresh = 0;
        @(posedge clk);
        #1;
        if (want_a) void'(alloc_q.pop_front());
        if (want_f) void'(free_q.pop_front());
    endtask

    // Asynchronous reset pulse started mid-cycle; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        zero_chk("rst_async");
        @(negedge clk);
        zero_chk("rst_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_mode = 0;
        m_streak = 0;
        m_fresh = 1;
    endtask

    task automatic push_alloc(input logic [IW-1:0] id, input logic [DW-1:0] size);
        aop_t a;
        a.id = id;
        a.size = size;
        alloc_q.push_back(a);
    endtask

    initial begin
        logic [12:0] order;
        int p0;
        rst = 1'b1;
        alloc_empty = 1'b1; free_empty = 1'b1;
        alloc_id = '0; alloc_size = '0; free_addr = '0;
        core_req_rdy = 0; core_rsp_val = 0; core_rsp_data = '0; resp_full = 0;
        m_mode = 0; m_streak = 0; m_fresh = 1; pushes = 0; last_resp = '0;
        m_alloc = 0; m_id = '0; m_size = '0; m_addr = '0;
        @(negedge clk);
        zero_chk("init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Alloc-only: the fresh cycle after release must not pop.
        push_alloc(8'h12, 64'h40);
        core_req_rdy = 1; core_rsp_val = 1; core_rsp_data = 64'h1000;
        for (int i = 0; i < 4; i++) tick();
        chk("alloc_only_resp", last_resp, {8'h12, 64'h1000});
        chk("alloc_only_q", alloc_q.size(), 0);

        // Free-only.
        free_q.push_back(64'h2000);
        core_rsp_data = 64'h1;
        for (int i = 0; i < 3; i++) tick();
        chk("free_only_resp", last_resp, {8'hFF, 64'h1});

        // Fairness: 10 allocs and 3 frees queued together.
        grants.delete();
        for (int i = 0; i < 10; i++) push_alloc(8'(i), 64'(16 * (i + 1)));
        for (int i = 0; i < 3; i++) free_q.push_back(64'(32'h8000 + i));
        for (int i = 0; i < 200; i++) begin
            if (alloc_q.size() == 0 && free_q.size() == 0 && m_mode == 0) break;
            core_rsp_data = {$urandom, $urandom};
            tick();
        end
        chk("fair_drained", alloc_q.size() + free_q.size() + m_mode, 0);
        chk("fair_count", grants.size(), 13);
        order = '0;
        foreach (grants[i]) order = {order[11:0], grants[i]};
        chk("fair_order", order, 13'b1111011110110);

        // Backpressure on request and on response.
        push_alloc(8'h33, 64'h99);
        core_req_rdy = 0; core_rsp_val = 0;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("bp_no_pop", alloc_q.size(), 0);
        core_req_rdy = 1;
        tick();
        p0 = pushes;
        core_req_rdy = 0; core_rsp_val = 1; resp_full = 1; core_rsp_data = 64'hABC;
        for (int i = 0; i < 3; i++) tick();
        chk("bp_full_no_push", pushes - p0, 0);
        resp_full = 0;
        tick();
        chk("bp_push", pushes - p0, 1);
        chk("bp_resp", last_resp, {8'h33, 64'hABC});

        // Reset while waiting for a result: op dropped, next queued op served.
        push_alloc(8'h44, 64'h10);
        push_alloc(8'h55, 64'h20);
        core_req_rdy = 1; core_rsp_val = 0;
        tick();
        tick();
        chk("rst_in_wait", m_mode, 2);
        p0 = pushes;
        core_rsp_val = 1; core_rsp_data = 64'h777;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (pushes != p0) break;
            tick();
        end
        chk("rst_next_push", pushes - p0, 1);
        chk("rst_next_resp", last_resp, {8'h55, 64'h777});

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0 && alloc_q.size() < 6)
                push_alloc(8'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 4) == 0 && free_q.size() < 6)
                free_q.push_back({$urandom, $urandom});
            core_req_rdy  = $urandom_range(0, 1);
            core_rsp_val  = $urandom_range(0, 1);
            resp_full     = ($urandom_range(0, 3) == 0);
            core_rsp_data = {$urandom, $urandom};
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
